// File: rtl/sram_fifo_if.sv
// sram_fifo_if: producer/consumer handshake plus the 1R1W SRAM port of the
// FWFT FIFO controller, bundled so the controller takes a single bus port.
// slave  = FIFO controller side, master = user / SRAM-model side.
interface sram_fifo_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 64
);
    localparam int unsigned ADDR_WIDTH  = $clog2(SIZE);
    localparam int unsigned COUNT_WIDTH = $clog2(SIZE + 1);

    logic                   flush_en;
    logic                   enqueue_en;
    logic [WIDTH-1:0]       enqueue_value;
    logic                   full;
    logic                   almost_full;
    logic                   dequeue_en;
    logic [WIDTH-1:0]       dequeue_value;
    logic                   empty;
    logic                   almost_empty;
    logic [COUNT_WIDTH-1:0] count;
    logic                   error;

    logic                   sram_write_en;
    logic [ADDR_WIDTH-1:0]  sram_write_addr;
    logic [WIDTH-1:0]       sram_write_data;
    logic                   sram_read_en;
    logic [ADDR_WIDTH-1:0]  sram_read_addr;
    logic [WIDTH-1:0]       sram_read_data;

    modport slave (
        input  flush_en, enqueue_en, enqueue_value, dequeue_en, sram_read_data,
        output full, almost_full, dequeue_value, empty, almost_empty, count, error,
        output sram_write_en, sram_write_addr, sram_write_data,
        output sram_read_en, sram_read_addr
    );

    modport master (
        output flush_en, enqueue_en, enqueue_value, dequeue_en, sram_read_data,
        input  full, almost_full, dequeue_value, empty, almost_empty, count, error,
        input  sram_write_en, sram_write_addr, sram_write_data,
        input  sram_read_en, sram_read_addr
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: first-word-fall-through FIFO controller driving a 1R1W SRAM
// with 1-cycle synchronous reads. The head read is re-issued every cycle at
// the next-head address, so sram_read_data always holds the presented head and
// no skid register is needed. A read never targets the slot written in the
// same cycle, so the SRAM's read-during-write behaviour is irrelevant.
// Optional feature macro: SRAM_FIFO_ERROR_CHECK_EN (sticky misuse flag on error).
module sram_fifo_ctrl #(
    parameter int unsigned WIDTH                  = 32,
    parameter int unsigned SIZE                   = 64,
    parameter int unsigned ALMOST_FULL_THRESHOLD  = SIZE,
    parameter int unsigned ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic       clk,
    input  logic       reset,
    sram_fifo_if.slave bus
);
    localparam int unsigned ADDR_WIDTH  = $clog2(SIZE);
    localparam int unsigned COUNT_WIDTH = $clog2(SIZE + 1);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(SIZE - 1);
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(SIZE);

    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [ADDR_WIDTH-1:0]  wr_ptr_next_c;
    logic [ADDR_WIDTH-1:0]  rd_ptr_next_c;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_next_c;
    logic [COUNT_WIDTH-1:0] remain_c;
    logic                   head_valid;
    logic                   full_q;
    logic                   almost_full_q;
    logic                   almost_empty_q;
    logic                   enq_c;
    logic                   deq_c;
    logic                   read_en_c;

    // Accept decisions, pointer advance with wrap, and next-head read scheduling
    always_comb begin
        enq_c         = bus.enqueue_en & ~full_q & ~bus.flush_en;
        deq_c         = bus.dequeue_en & head_valid & ~bus.flush_en;
        wr_ptr_next_c = wr_ptr;
        rd_ptr_next_c = rd_ptr;
        if (enq_c) begin
            wr_ptr_next_c = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_WIDTH'(1);
        end
        if (deq_c) begin
            rd_ptr_next_c = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_WIDTH'(1);
        end
        // Entries still stored after this cycle's pop, excluding this cycle's push
        remain_c     = count_q - COUNT_WIDTH'(deq_c);
        read_en_c    = (remain_c != '0) & ~bus.flush_en;
        count_next_c = bus.flush_en ? '0
                     : count_q + COUNT_WIDTH'(enq_c) - COUNT_WIDTH'(deq_c);
    end

    // Pointer, occupancy, head-valid and registered level flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            head_valid     <= 1'b0;
            full_q         <= 1'b0;
            almost_full_q  <= (ALMOST_FULL_THRESHOLD == 0);
            almost_empty_q <= 1'b1;
        end else begin
            if (bus.flush_en) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr_next_c;
                rd_ptr <= rd_ptr_next_c;
            end
            count_q        <= count_next_c;
            head_valid     <= read_en_c;
            full_q         <= (count_next_c == FULL_COUNT);
            almost_full_q  <= (32'(count_next_c) >= ALMOST_FULL_THRESHOLD);
            almost_empty_q <= (32'(count_next_c) <= ALMOST_EMPTY_THRESHOLD);
        end
    end

`ifdef SRAM_FIFO_ERROR_CHECK_EN
    logic error_q;

    // Sticky flag for push-while-full or pop-while-empty; cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if ((bus.enqueue_en & full_q) | (bus.dequeue_en & ~head_valid)) begin
            error_q <= 1'b1;
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.full            = full_q;
    assign bus.almost_full     = almost_full_q;
    assign bus.almost_empty    = almost_empty_q;
    assign bus.count           = count_q;
    assign bus.empty           = ~head_valid;
    assign bus.dequeue_value   = WIDTH'(bus.sram_read_data);
    assign bus.sram_write_en   = enq_c;
    assign bus.sram_write_addr = wr_ptr;
    assign bus.sram_write_data = WIDTH'(bus.enqueue_value);
    assign bus.sram_read_en    = read_en_c;
    assign bus.sram_read_addr  = rd_ptr_next_c;
endmodule
